// File: rtl/click_fifo_pkg.sv
// Shared types and helpers for the click FIFO: phase reset value and output FSM encoding.
package click_fifo_pkg;

    localparam logic PHASE_RST = 1'b0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } out_state_t;

    // A 2-phase channel carries an outstanding token whenever request and acknowledge differ.
    function automatic logic token_pending(input logic req, input logic ack);
        return req ^ ack;
    endfunction

endpackage

// File: rtl/click_sync.sv
// Flop chain that brings a 2-phase handshake wire into the clk domain;
// with STAGES == 0 the wire passes straight through.
module click_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    generate
        if (STAGES == 0) begin : g_bypass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ reset;
            assign q = d;
        end else begin : g_chain
            logic [STAGES-1:0] chain;

            // Shift the handshake level through the synchroniser stages.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    chain <= {STAGES{1'b0}};
                end else begin
                    chain[0] <= d;
                    for (int i = 1; i < STAGES; i++) begin
                        chain[i] <= chain[i-1];
                    end
                end
            end

            assign q = chain[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/click_fifo.sv
// DEPTH-entry FIFO between two 2-phase bundled-data channels, with optional
// synchronisers on the incoming request and acknowledge wires.
module click_fifo
    import click_fifo_pkg::*;
#(
    parameter int DATA_W      = 2,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_W-1:0]           in_data,
    input  logic                        in_req,
    output logic                        in_ack,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_req,
    input  logic                        out_ack,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        full,
    output logic                        empty
);

    localparam int ADDR_W = $clog2(DEPTH);

    typedef logic [ADDR_W:0]   cnt_t;
    typedef logic [ADDR_W-1:0] ptr_t;

    localparam cnt_t DEPTH_CNT = cnt_t'(DEPTH);
    localparam cnt_t ZERO_CNT  = {(ADDR_W+1){1'b0}};
    localparam ptr_t ONE_PTR   = ptr_t'(1);

    logic              in_req_s;
    logic              out_ack_s;
    logic [DATA_W-1:0] mem [DEPTH];
    ptr_t              wr_ptr;
    ptr_t              rd_ptr;
    out_state_t        state;
    out_state_t        state_next;
    logic              push;
    logic              pop;
    logic              load;
    cnt_t              count_next;

    click_sync #(.STAGES(SYNC_STAGES)) u_in_req_sync (
        .clk   (clk),
        .reset (reset),
        .d     (in_req),
        .q     (in_req_s)
    );

    click_sync #(.STAGES(SYNC_STAGES)) u_out_ack_sync (
        .clk   (clk),
        .reset (reset),
        .d     (out_ack),
        .q     (out_ack_s)
    );

    // Accept a pending input token only when the registered count says there is room.
    always_comb begin
        push = token_pending(in_req_s, in_ack) && !full;
    end

    // Output FSM: offer the head entry when idle, retire it once the consumer acknowledges.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        pop        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (count != ZERO_CNT) begin
                    load       = 1'b1;
                    state_next = ST_PEND;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_PEND: begin
                if (!token_pending(out_req, out_ack_s)) begin
                    pop        = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_PEND;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Occupancy includes the entry currently offered to the consumer.
    always_comb begin
        count_next = count + cnt_t'(push) - cnt_t'(pop);
    end

    // Output FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Write side: storage, write pointer and input acknowledge phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= {DATA_W{1'b0}};
            end
            wr_ptr <= {ADDR_W{1'b0}};
            in_ack <= PHASE_RST;
        end else if (push) begin
            mem[wr_ptr] <= in_data;
            wr_ptr      <= wr_ptr + ONE_PTR;
            in_ack      <= ~in_ack;
        end
    end

    // Read side: head data is captured once per offer and held until the next offer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr   <= {ADDR_W{1'b0}};
            out_req  <= PHASE_RST;
            out_data <= {DATA_W{1'b0}};
        end else begin
            if (load) begin
                out_data <= mem[rd_ptr];
                out_req  <= ~out_req;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ONE_PTR;
            end
        end
    end

    // Registered occupancy and flags, all updated together so they never disagree.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= ZERO_CNT;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            count <= count_next;
            full  <= (count_next == DEPTH_CNT);
            empty <= (count_next == ZERO_CNT);
        end
    end

endmodule

// File: tb/tb_click_fifo.sv
// Directed bench for click_fifo (DATA_W=2, DEPTH=4, SYNC_STAGES=2).
module tb_click_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] in_data;
    logic       in_req;
    logic       in_ack;
    logic [1:0] out_data;
    logic       out_req;
    logic       out_ack;
    logic [2:0] count;
    logic       full;
    logic       empty;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    click_fifo #(.DATA_W(2), .DEPTH(4), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_req   (in_req),
        .in_ack   (in_ack),
        .out_data (out_data),
        .out_req  (out_req),
        .out_ack  (out_ack),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_token(input logic [1:0] d);
        int n;
        n = 0;
        in_data = d;
        in_req  = ~in_req;
        while (in_ack !== in_req && n < 20) begin
            tick();
            n++;
        end
        tests++;
        if (in_ack !== in_req) begin
            fails++;
            $display("FAIL push_ack: in_ack=%b expected %b after %0d cycles", in_ack, in_req, n);
        end
    endtask

    task automatic take_token(input logic [1:0] exp, input int delay);
        int n;
        n = 0;
        while (out_req === out_ack && n < 40) begin
            tick();
            n++;
        end
        tests++;
        if (out_req === out_ack) begin
            fails++;
            $display("FAIL offer_timeout: out_req=%b expected %b", out_req, ~out_ack);
        end
        tests++;
        if (out_data !== exp) begin
            fails++;
            $display("FAIL take_data: out_data=%b expected %b", out_data, exp);
        end
        repeat (delay) tick();
        out_ack = ~out_ack;
        tick();
    endtask

    task automatic wait_drained();
        int n;
        n = 0;
        while (count !== 3'd0 && n < 20) begin
            tick();
            n++;
        end
        tests++;
        if (count !== 3'd0 || empty !== 1'b1) begin
            fails++;
            $display("FAIL drained: count=%0d empty=%b expected 0 1", count, empty);
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        in_req  = 1'b0;
        out_ack = 1'b0;
        in_data = 2'b00;
        tick();
        tick();
        tests++;
        if (in_ack !== 1'b0 || out_req !== 1'b0) begin
            fails++;
            $display("FAIL reset_phase: in_ack=%b out_req=%b expected 0 0", in_ack, out_req);
        end
        tests++;
        if (out_data !== 2'b00 || count !== 3'd0) begin
            fails++;
            $display("FAIL reset_data: out_data=%b count=%0d expected 00 0", out_data, count);
        end
        tests++;
        if (empty !== 1'b1 || full !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags: empty=%b full=%b expected 1 0", empty, full);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        in_data = 2'b10;
        in_req  = ~in_req;
        tick();
        tick();
        tests++;
        if (in_ack !== 1'b0) begin
            fails++;
            $display("FAIL single_early_ack: in_ack=%b expected 0", in_ack);
        end
        tick();
        tests++;
        if (in_ack !== 1'b1 || count !== 3'd1 || out_req !== 1'b0) begin
            fails++;
            $display("FAIL single_edge3: in_ack=%b count=%0d out_req=%b expected 1 1 0", in_ack, count, out_req);
        end
        tick();
        tests++;
        if (out_req !== 1'b1 || out_data !== 2'b10 || count !== 3'd1) begin
            fails++;
            $display("FAIL single_edge4: out_req=%b out_data=%b count=%0d expected 1 10 1", out_req, out_data, count);
        end
    endtask

    task automatic test_drain();
        out_ack = ~out_ack;
        tick();
        tick();
        tests++;
        if (count !== 3'd1) begin
            fails++;
            $display("FAIL drain_early: count=%0d expected 1", count);
        end
        tick();
        tests++;
        if (count !== 3'd0 || empty !== 1'b1) begin
            fails++;
            $display("FAIL drain_edge3: count=%0d empty=%b expected 0 1", count, empty);
        end
        tests++;
        if (out_req !== 1'b1 || out_data !== 2'b10) begin
            fails++;
            $display("FAIL drain_hold: out_req=%b out_data=%b expected 1 10", out_req, out_data);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            push_token(2'(i));
        end
        tests++;
        if (count !== 3'd4 || full !== 1'b1) begin
            fails++;
            $display("FAIL fill_full: count=%0d full=%b expected 4 1", count, full);
        end
        in_data = 2'b01;
        in_req  = ~in_req;
        repeat (6) tick();
        tests++;
        if (in_ack === in_req || count !== 3'd4) begin
            fails++;
            $display("FAIL fill_blocked: in_ack=%b count=%0d expected %b 4", in_ack, count, ~in_req);
        end
        out_ack = ~out_ack;
        tick();
        tick();
        tick();
        tests++;
        if (count !== 3'd3 || full !== 1'b0 || in_ack === in_req) begin
            fails++;
            $display("FAIL fill_pop: count=%0d full=%b in_ack=%b expected 3 0 %b", count, full, in_ack, ~in_req);
        end
        tick();
        tests++;
        if (in_ack !== in_req || count !== 3'd4) begin
            fails++;
            $display("FAIL fill_late_push: in_ack=%b count=%0d expected %b 4", in_ack, count, in_req);
        end
        tests++;
        if (out_data !== 2'b01) begin
            fails++;
            $display("FAIL fill_next_head: out_data=%b expected 01", out_data);
        end
        take_token(2'b01, 0);
        take_token(2'b10, 1);
        take_token(2'b11, 0);
        take_token(2'b01, 2);
        wait_drained();
    endtask

    task automatic test_stream();
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    push_token(2'(i));
                end
            end
            begin
                for (int j = 0; j < 10; j++) begin
                    take_token(2'(j), int'($urandom_range(0, 5)));
                end
            end
        join
        wait_drained();
    endtask

    task automatic test_simultaneous();
        push_token(2'b01);
        push_token(2'b10);
        tick();
        tests++;
        if (count !== 3'd2 || out_req === out_ack || out_data !== 2'b01) begin
            fails++;
            $display("FAIL simul_setup: count=%0d out_req=%b out_data=%b expected 2 %b 01", count, out_req, out_data, ~out_ack);
        end
        in_data = 2'b11;
        in_req  = ~in_req;
        out_ack = ~out_ack;
        tick();
        tick();
        tests++;
        if (count !== 3'd2 || in_ack === in_req) begin
            fails++;
            $display("FAIL simul_before: count=%0d in_ack=%b expected 2 %b", count, in_ack, ~in_req);
        end
        tick();
        tests++;
        if (count !== 3'd2 || in_ack !== in_req || out_req !== out_ack) begin
            fails++;
            $display("FAIL simul_edge: count=%0d in_ack=%b out_req=%b expected 2 %b %b", count, in_ack, out_req, in_req, out_ack);
        end
        tick();
        tests++;
        if (out_req === out_ack || out_data !== 2'b10 || count !== 3'd2) begin
            fails++;
            $display("FAIL simul_next: out_req=%b out_data=%b count=%0d expected %b 10 2", out_req, out_data, count, ~out_ack);
        end
        take_token(2'b10, 0);
        take_token(2'b11, 0);
        wait_drained();
    endtask

    task automatic test_reset_mid();
        push_token(2'b11);
        push_token(2'b10);
        push_token(2'b01);
        tick();
        tests++;
        if (count !== 3'd3 || out_req === out_ack || out_data !== 2'b11) begin
            fails++;
            $display("FAIL mid_setup: count=%0d out_req=%b out_data=%b expected 3 %b 11", count, out_req, out_data, ~out_ack);
        end
        reset   = 1'b1;
        in_req  = 1'b0;
        out_ack = 1'b0;
        #1;
        tests++;
        if (in_ack !== 1'b0 || out_req !== 1'b0 || out_data !== 2'b00 || count !== 3'd0) begin
            fails++;
            $display("FAIL mid_async: in_ack=%b out_req=%b out_data=%b count=%0d expected 0 0 00 0", in_ack, out_req, out_data, count);
        end
        tests++;
        if (empty !== 1'b1 || full !== 1'b0) begin
            fails++;
            $display("FAIL mid_flags: empty=%b full=%b expected 1 0", empty, full);
        end
        tick();
        tick();
        reset = 1'b0;
        tick();
        in_data = 2'b01;
        in_req  = 1'b1;
        tick();
        tick();
        tests++;
        if (in_ack !== 1'b0) begin
            fails++;
            $display("FAIL post_early_ack: in_ack=%b expected 0", in_ack);
        end
        tick();
        tests++;
        if (in_ack !== 1'b1 || count !== 3'd1) begin
            fails++;
            $display("FAIL post_edge3: in_ack=%b count=%0d expected 1 1", in_ack, count);
        end
        tick();
        tests++;
        if (out_req !== 1'b1 || out_data !== 2'b01) begin
            fails++;
            $display("FAIL post_edge4: out_req=%b out_data=%b expected 1 01", out_req, out_data);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_drain();
        test_fill();
        test_stream();
        test_simultaneous();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
